cfg_loader: RTL and testbench
=============================

# cfg_loader

Serial configuration loader for the logic-cell array. It accepts a framed, bit-serial configuration stream, checks it, and drives the static data and select inputs of the C1/C2/S1/S2-style cells from one wide configuration bus. It sits directly upstream of the cell array. Cells only ever see a complete, validated configuration: the new bus value is committed atomically, and only after the whole stream has passed its checks.

## Interface
Parameters:
- NUM_CELLS, 4, number of cell frames in one stream
- FRAME_W, 8, configuration bits per cell

Ports:
- clk  in  1  clock; all state updates on the rising edge
- clr_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE, DONE and ERROR
- din  in  1  serial stream bit
- din_valid  in  1  din is valid this cycle
- din_ready  out  1  loader accepts a bit this cycle
- cfg_out  out  NUM_CELLS*FRAME_W  committed configuration; frame i is cfg_out[i*FRAME_W +: FRAME_W]
- cfg_valid  out  1  cfg_out holds a configuration committed by the last load
- busy  out  1  high in SYNC, LOAD and CHECK
- err  out  1  last load failed

## Operation
- A bit is accepted when din_valid and din_ready are both high on a rising clk edge. Bits are received MSB-first within every byte and every frame.
- Stream format, in order:
  - sync byte 0xA5;
  - NUM_CELLS frames, frame 0 first;
  - checksum byte (CHECKSUM build only, see Configuration).
- FSM states: IDLE, SYNC, LOAD, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR -> SYNC on start:
  - clears err and cfg_valid;
  - resets the bit counter, frame counter and running checksum.
- SYNC:
  - shifts 8 bits into a shift register;
  - on the 8th bit: goes to LOAD if the byte equals 0xA5, otherwise to ERROR.
- LOAD:
  - shifts bits into a shadow register of NUM_CELLS*FRAME_W bits;
  - at each frame boundary, XORs the completed frame into an 8-bit running checksum, folded in 8-bit chunks when FRAME_W > 8;
  - after the last bit of frame NUM_CELLS-1, goes to CHECK.
- CHECK:
  - shifts 8 bits;
  - on the 8th bit: goes to DONE if the byte equals the running checksum, otherwise to ERROR.
- DONE:
  - on entry, the shadow register is copied to cfg_out and cfg_valid is set.
- ERROR:
  - on entry, err is set; cfg_out and cfg_valid keep their values (cfg_valid is already 0 from start).
- din_ready is high only in SYNC, LOAD and CHECK.
- start is ignored while busy.
- din_valid outside SYNC/LOAD/CHECK is ignored.

## Timing
- Reset values: cfg_out = 0, cfg_valid = 0, err = 0, busy = 0, din_ready = 0; FSM in IDLE. Counters and shadow register are cleared.
- start -> busy and din_ready high on the next cycle.
- Accepted beats per load: 8 + NUM_CELLS*FRAME_W + 8. A stall (din_valid low) freezes all counters with no penalty.
- Commit: cfg_out, cfg_valid and busy change on the edge that accepts the final bit; the new values are visible the following cycle. cfg_out never shows a partial frame.
- Error: err rises on the edge that accepts the 8th bit of a bad sync or checksum byte; busy falls on the same edge.
- Reset asserted mid-load returns everything to the reset values immediately, including a previously committed cfg_out.
- start in the same cycle as a DONE/ERROR transition is not seen; it must be reasserted.

## Configuration
- Macro: CFG_LOADER_CHECKSUM_EN.
- Defined: the CHECK state exists and the trailing checksum byte is required, as described above.
- Undefined:
  - CHECK and the checksum logic are removed;
  - LOAD goes directly to DONE after the last frame bit;
  - beat count is 8 + NUM_CELLS*FRAME_W;
  - err can be set only by a bad sync byte.

## Test plan
- Defaults, CHECKSUM build, stream 0xA5, 0x12, 0x34, 0x56, 0x78, 0x08 -> after beat 48: cfg_out = 0x78563412, cfg_valid = 1, err = 0, busy = 0.
- Same stream with checksum byte 0x09 -> err = 1, cfg_valid = 0, cfg_out keeps its prior value.
- Sync byte 0xA4 -> ERROR after 8 beats, din_ready = 0, err = 1; a following start plus a valid stream clears err and commits.
- Valid stream with din_valid deasserted at random cycles (for example every third cycle) -> same cfg_out as the unstalled run; commit occurs only after all 48 accepted beats.
- clr_n pulsed low at beat 20 of a second load, after a successful first load -> cfg_out = 0 and all outputs at reset values; start pulsed while busy has no effect.
- Build without CHECKSUM_EN, stream 0xA5, 0x12, 0x34, 0x56, 0x78 -> commit after beat 40 with cfg_out = 0x78563412.

Source files
------------

// File: rtl/cfg_loader_if.sv
// Handshake and configuration bus between the stream source and cfg_loader.
// The master side drives the serial stream; the slave side (the loader) returns the config.
interface cfg_loader_if #(
    parameter int unsigned NUM_CELLS = 4,
    parameter int unsigned FRAME_W   = 8
);
    logic                           start;
    logic                           din;
    logic                           din_valid;
    logic                           din_ready;
    logic [NUM_CELLS*FRAME_W-1:0]   cfg_out;
    logic                           cfg_valid;
    logic                           busy;
    logic                           err;

    modport master (
        output start, din, din_valid,
        input  din_ready, cfg_out, cfg_valid, busy, err
    );

    modport slave (
        input  start, din, din_valid,
        output din_ready, cfg_out, cfg_valid, busy, err
    );
endinterface

// File: rtl/cfg_loader.sv
// Serial configuration loader: sync byte, NUM_CELLS frames, optional checksum byte, atomic commit.
// Define CFG_LOADER_CHECKSUM_EN to require and verify the trailing XOR checksum byte.
module cfg_loader #(
    parameter int unsigned NUM_CELLS = 4,
    parameter int unsigned FRAME_W   = 8
) (
    input logic       clk,
    input logic       clr_n,
    cfg_loader_if.slave bus
);
    localparam int unsigned TotW  = NUM_CELLS * FRAME_W;
    localparam int unsigned BitW  = $clog2((FRAME_W > 8) ? FRAME_W : 8);
    localparam int unsigned FcW   = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam logic [BitW-1:0] ByteLast     = BitW'(7);
    localparam logic [BitW-1:0] FrameLast    = BitW'(FRAME_W - 1);
    localparam logic [FcW-1:0]  FrameCntLast = FcW'(NUM_CELLS - 1);
    localparam logic [7:0]      SyncByte     = 8'hA5;

`ifdef CFG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StSync, StLoad, StCheck, StDone, StError} state_e;
`else
    typedef enum logic [2:0] {StIdle, StSync, StLoad, StDone, StError} state_e;
`endif

    state_e             state_q, state_d;
    logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FcW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [7:0]         byte_q, byte_d;
    logic [FRAME_W-1:0] frm_q, frm_d;
    logic [TotW-1:0]    shadow_q, shadow_d;
    logic [TotW-1:0]    cfg_q, cfg_d;
    logic               cfg_valid_q, cfg_valid_d;
    logic               err_q, err_d;
    logic               active;
    logic               accept;

`ifdef CFG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Wide frames fold into the checksum 8 bits at a time, LSB-aligned.
    function automatic logic [7:0] fold8(input logic [FRAME_W-1:0] f);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < FRAME_W; i++) begin
            r[i % 8] = r[i % 8] ^ f[i];
        end
        return r;
    endfunction
`endif

    always_comb begin
        active = (state_q == StSync) || (state_q == StLoad)
`ifdef CFG_LOADER_CHECKSUM_EN
                 || (state_q == StCheck)
`endif
                 ;
    end

    assign accept        = active & bus.din_valid;
    assign bus.din_ready = active;
    assign bus.busy      = active;
    assign bus.cfg_out   = cfg_q;
    assign bus.cfg_valid = cfg_valid_q;
    assign bus.err       = err_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        byte_d      = byte_q;
        frm_d       = frm_q;
        shadow_d    = shadow_q;
        cfg_d       = cfg_q;
        cfg_valid_d = cfg_valid_q;
        err_d       = err_q;
`ifdef CFG_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (bus.start) begin
                    state_d     = StSync;
                    err_d       = 1'b0;
                    cfg_valid_d = 1'b0;
                    bit_cnt_d   = '0;
                    frame_cnt_d = '0;
`ifdef CFG_LOADER_CHECKSUM_EN
                    csum_d      = '0;
`endif
                end
            end
            StSync: begin
                if (accept) begin
                    byte_d    = {byte_q[6:0], bus.din};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == ByteLast) begin
                        bit_cnt_d = '0;
                        if (byte_d == SyncByte) begin
                            state_d = StLoad;
                        end else begin
                            state_d = StError;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    frm_d     = (frm_q << 1) | FRAME_W'(bus.din);
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == FrameLast) begin
                        bit_cnt_d   = '0;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        // Frame 0 arrives first and ends up in the lowest slice.
                        shadow_d    = (shadow_q >> FRAME_W) | (TotW'(frm_d) << (TotW - FRAME_W));
`ifdef CFG_LOADER_CHECKSUM_EN
                        csum_d      = csum_q ^ fold8(frm_d);
                        if (frame_cnt_q == FrameCntLast) begin
                            state_d = StCheck;
                        end
`else
                        if (frame_cnt_q == FrameCntLast) begin
                            state_d     = StDone;
                            cfg_d       = shadow_d;
                            cfg_valid_d = 1'b1;
                        end
`endif
                    end
                end
            end
`ifdef CFG_LOADER_CHECKSUM_EN
            StCheck: begin
                if (accept) begin
                    byte_d    = {byte_q[6:0], bus.din};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == ByteLast) begin
                        bit_cnt_d = '0;
                        if (byte_d == csum_q) begin
                            state_d     = StDone;
                            cfg_d       = shadow_q;
                            cfg_valid_d = 1'b1;
                        end else begin
                            state_d = StError;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            byte_q      <= '0;
            frm_q       <= '0;
            shadow_q    <= '0;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            byte_q      <= byte_d;
            frm_q       <= frm_d;
            shadow_q    <= shadow_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            err_q       <= err_d;
        end
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif
endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader: table of streams, scoreboard of expected commits,
// plus hand-written reset and start-timing sequences.
module tb_cfg_loader;
    localparam int unsigned NumCells = 4;
    localparam int unsigned FrameW   = 8;
`ifdef CFG_LOADER_CHECKSUM_EN
    localparam bit CkEn = 1'b1;
`else
    localparam bit CkEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    cfg_loader_if #(.NUM_CELLS(NumCells), .FRAME_W(FrameW)) bus ();

    cfg_loader #(.NUM_CELLS(NumCells), .FRAME_W(FrameW)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0]  sync;
        logic [31:0] frames;
        logic        bad_csum;
        logic        stall;
        logic        mid_start;
        logic        hold_start;
        logic        exp_err_ck;
        logic        exp_err_nock;
    } vec_t;

    typedef struct packed {
        logic [31:0] cfg;
        logic        valid;
        logic        err;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    exp_t sb_q[$];
    logic [31:0] model_cfg = '0;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic b, input logic stall);
        if (stall) begin
            stall_cnt++;
            if (stall_cnt % 3 == 0) begin
                bus.din_valid = 1'b0;
                bus.din       = ~b;
                @(posedge clk);
                #1;
            end
        end
        bus.din       = b;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic start_load();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("start_busy_ready", {30'd0, bus.busy, bus.din_ready}, 32'd3);
    endtask

    task automatic run_load(input vec_t v);
        logic  bits_q[$];
        logic [7:0] ck;
        logic [7:0] fb;
        exp_t  e;
        exp_t  got;
        ck = v.frames[7:0] ^ v.frames[15:8] ^ v.frames[23:16] ^ v.frames[31:24];
        if (v.bad_csum) ck = ck ^ 8'h01;
        e.err   = CkEn ? v.exp_err_ck : v.exp_err_nock;
        e.valid = !e.err;
        if (e.valid) model_cfg = v.frames;
        e.cfg = model_cfg;
        sb_q.push_back(e);

        for (int i = 7; i >= 0; i--) bits_q.push_back(v.sync[i]);
        if (v.sync == 8'hA5) begin
            for (int f = 0; f < 4; f++) begin
                fb = v.frames[f*8 +: 8];
                for (int i = 7; i >= 0; i--) bits_q.push_back(fb[i]);
            end
            if (CkEn) for (int i = 7; i >= 0; i--) bits_q.push_back(ck[i]);
        end

        start_load();
        for (int i = 0; i < bits_q.size(); i++) begin
            if (i == bits_q.size() - 1) begin
                check("pre_commit", {29'd0, bus.busy, bus.cfg_valid, bus.err}, 32'd4);
                if (v.hold_start) bus.start = 1'b1;
            end
            if (v.mid_start && i == 12) bus.start = 1'b1;
            beat(bits_q[i], v.stall);
            bus.start = 1'b0;
        end

        for (int k = 0; k < 4 && bus.busy; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got 0 entries expected 1");
        end else begin
            got = sb_q.pop_front();
            check("cfg_out", bus.cfg_out, got.cfg);
            check("cfg_valid", {31'd0, bus.cfg_valid}, {31'd0, got.valid});
            check("err", {31'd0, bus.err}, {31'd0, got.err});
            check("busy_done", {31'd0, bus.busy}, 32'd0);
            check("ready_done", {31'd0, bus.din_ready}, 32'd0);
        end

        if (v.hold_start) begin
            @(posedge clk);
            #1;
            check("start_at_commit_ignored", {31'd0, bus.busy}, 32'd0);
        end
        if (v.sync != 8'hA5) begin
            for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
            check("err_hold_after_bad_sync", {30'd0, bus.err, bus.busy}, 32'd2);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;

        //            sync   frames        bad stl mid hld eck enk
        vecs[0] = '{8'hA5, 32'h78563412, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 32'h78563412, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hA4, 32'h78563412, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'hA5, 32'h78563412, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'hA5, 32'h00FF00FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h5A, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{8'hA5, 32'hCAFE0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        #12;
        check("rst_cfg_out", bus.cfg_out, 32'd0);
        check("rst_flags", {28'd0, bus.cfg_valid, bus.err, bus.busy, bus.din_ready}, 32'd0);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_rst", {30'd0, bus.busy, bus.din_ready}, 32'd0);

        for (int n = 0; n < 8; n++) begin
            run_load(vecs[n]);
        end

        // Reset in the middle of a second load wipes the committed config too.
        start_load();
        for (int i = 0; i < 20; i++) begin
            logic [31:0] src;
            src = 32'hA5123456;
            beat(src[31-i], 1'b0);
        end
        check("busy_mid_load", {31'd0, bus.busy}, 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        check("midrst_cfg_out", bus.cfg_out, 32'd0);
        check("midrst_flags", {28'd0, bus.cfg_valid, bus.err, bus.busy, bus.din_ready}, 32'd0);
        model_cfg = '0;
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        run_load(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
